// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory access sequencer.
//   - dmem_state_e : 3-bit encoding of the five sequencer states
//   - DMEM_ADDR_W / DMEM_DATA_W : default address and data widths
//   - MEM_LAT_MIN / MEM_LAT_MAX : legal range of the memory read latency
//   - lat_cnt_load() : value loaded into the latency counter on a read launch
package dmem_ctrl_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    // Wide enough to hold MEM_LAT_MAX-1.
    localparam int LAT_CNT_W   = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_EDGE = 3'd1,
        ST_ACCESS    = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_RESP      = 3'd4
    } dmem_state_e;

    // The counter runs MEM_LAT-1 .. 0, so WAIT_DATA lasts MEM_LAT cycles.
    function automatic logic [LAT_CNT_W-1:0] lat_cnt_load(input int mem_lat);
        return LAT_CNT_W'(mem_lat - 1);
    endfunction

endpackage

// File: rtl/phase_edge_det.sv
// Rising-edge detector for a divided clock phase sampled on the system clock.
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset (clears the history flop)
//   phase_in   : divided phase level
//   phase_rise : combinational pulse, high in the cycle phase_in is 1 and
//                was 0 on the previous clock
module phase_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic phase_in,
    output logic phase_rise
);

    logic phase_q;
    logic phase_d;

    always_comb begin
        phase_d = phase_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_rise = phase_in & ~phase_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer between the MEM-stage request and a
// synchronous data memory. Each access is launched on a rising edge of the
// divided memory phase; the pipeline is stalled until the access completes.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   dmem_phase            : divided memory phase (level)
//   mem_read, mem_write   : MEM-stage load / store request (write wins)
//   addr, wdata           : request address / store data, held while stall=1
//   stall                 : freeze pipeline
//   done                  : one-cycle completion pulse
//   rdata                 : load result, held until the next load completes
//   mem_en, mem_we        : memory strobes, decoded from state only
//   mem_addr, mem_wdata   : memory address / write data, hold between accesses
//   mem_rdata             : memory read data, valid MEM_LAT cycles after mem_en
//   misalign              : (DMEM_ALIGN_CHECK_EN only) flags a rejected access
// Optional feature macro: DMEM_ALIGN_CHECK_EN -- requests with addr[1:0]!=0
// complete immediately with misalign=1 and never touch memory.
// MEM_LAT must lie in MEM_LAT_MIN..MEM_LAT_MAX.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dmem_phase,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = lat_cnt_load(MEM_LAT);

    dmem_state_e            state_q, state_d;
    logic                   op_write_q, op_write_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic                   phase_rise;
    logic                   req;

`ifdef DMEM_ALIGN_CHECK_EN
    logic                   misalign_q, misalign_d;
`endif

    phase_edge_det u_phase_edge_det (
        .clk        (clk),
        .reset      (reset),
        .phase_in   (dmem_phase),
        .phase_rise (phase_rise)
    );

    assign req = mem_read | mem_write;

    always_comb begin
        state_d     = state_q;
        op_write_d  = op_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_cnt_d   = lat_cnt_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // phase_rise is deliberately ignored here: an edge coinciding
                // with the request is missed and the access waits for the next.
                if (req) begin
                    op_write_d = mem_write;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    state_d    = ST_WAIT_EDGE;
`ifdef DMEM_ALIGN_CHECK_EN
                    if (addr[1:0] != 2'b00) begin
                        state_d    = ST_RESP;
                        misalign_d = 1'b1;
                    end
`endif
                end
            end
            ST_WAIT_EDGE: begin
                if (phase_rise) begin
                    // Load the memory-side registers on entry so they equal
                    // the latched request during ACCESS and hold afterwards.
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (op_write_q) begin
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = LAT_INIT;
                    state_d   = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (lat_cnt_q == '0) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_cnt_q   <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_write_q  <= op_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat_cnt_q   <= lat_cnt_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef DMEM_ALIGN_CHECK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    // Memory strobes depend only on registered state, never on CPU inputs.
    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = (state_q == ST_ACCESS) & op_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign done  = (state_q == ST_RESP);
    assign rdata = rdata_q;
    assign stall = ((state_q == ST_IDLE) & req)
                 | (state_q == ST_WAIT_EDGE)
                 | (state_q == ST_ACCESS)
                 | (state_q == ST_WAIT_DATA);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl. Two instances (MEM_LAT=1 and MEM_LAT=3) receive
// the same request stream, each with its own request lines and memory.
// Expected timing is derived per transaction from the phase schedule:
// access one cycle after the first phase rise strictly after the request,
// done one cycle after the access (write) or MEM_LAT+1 cycles after (read).
// Optional feature macro: DMEM_ALIGN_CHECK_EN.
module tb_dmem_access_ctrl;

    localparam int NI    = 2;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        dmem_phase;
    logic        mem_init;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read_i  [NI];
    logic        mem_write_i [NI];
    logic        stall_o     [NI];
    logic        done_o      [NI];
    logic        mem_en_o    [NI];
    logic        mem_we_o    [NI];
    logic [31:0] rdata_o     [NI];
    logic [31:0] mem_addr_o  [NI];
    logic [31:0] mem_wdata_o [NI];
    logic [31:0] mem_rdata_i [NI];
`ifdef DMEM_ALIGN_CHECK_EN
    logic        misalign_o  [NI];
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ph_off   = 0;

    logic [31:0] ref_mem    [64];
    logic [31:0] ref_rdata  [NI];
    logic [31:0] ref_maddr  [NI];
    logic [31:0] ref_mwdata [NI];

    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    // Divider model: one cycle low, five cycles high.
    function automatic bit phase_at(input int c);
        return ((c + ph_off + 600) % 6) != 0;
    endfunction

    function automatic bit rise_at(input int c);
        return phase_at(c) && !phase_at(c - 1);
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int L = (gi == 0) ? LAT_A : LAT_B;
        logic [31:0] mem  [64];
        logic [31:0] pipe [L];

        always @(posedge clk) begin
            if (mem_init) begin
                for (int k = 0; k < 64; k++) mem[k] <= init_word(k);
            end else if (mem_en_o[gi] && mem_we_o[gi]) begin
                mem[mem_addr_o[gi][7:2]] <= mem_wdata_o[gi];
            end
            // Poison value outside valid read slots exposes mistimed captures.
            pipe[0] <= (mem_en_o[gi] && !mem_we_o[gi]) ? mem[mem_addr_o[gi][7:2]]
                                                       : 32'h0BAD_0BAD;
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata_i[gi] = pipe[L-1];

        dmem_access_ctrl #(
            .ADDR_W  (32),
            .DATA_W  (32),
            .MEM_LAT (L)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .dmem_phase (dmem_phase),
            .mem_read   (mem_read_i[gi]),
            .mem_write  (mem_write_i[gi]),
            .addr       (addr),
            .wdata      (wdata),
            .stall      (stall_o[gi]),
            .done       (done_o[gi]),
            .rdata      (rdata_o[gi]),
            .mem_en     (mem_en_o[gi]),
            .mem_we     (mem_we_o[gi]),
            .mem_addr   (mem_addr_o[gi]),
            .mem_wdata  (mem_wdata_o[gi]),
            .mem_rdata  (mem_rdata_i[gi])
`ifdef DMEM_ALIGN_CHECK_EN
            ,
            .misalign   (misalign_o[gi])
`endif
        );
    end

    task automatic chk(input string tag, input int i, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s lat=%0d cyc=%0d observed=%h expected=%h",
                   tag, lat_of(i), cyc, obs, expv);
        end
    endtask

    task automatic check_inst(input int i, input bit e_stall, input bit e_done,
                              input bit e_en, input bit e_we);
        chk("stall",     i, 32'(stall_o[i]),  32'(e_stall));
        chk("done",      i, 32'(done_o[i]),   32'(e_done));
        chk("mem_en",    i, 32'(mem_en_o[i]), 32'(e_en));
        chk("mem_we",    i, 32'(mem_we_o[i]), 32'(e_we));
        chk("mem_addr",  i, mem_addr_o[i],    ref_maddr[i]);
        chk("mem_wdata", i, mem_wdata_o[i],   ref_mwdata[i]);
        chk("rdata",     i, rdata_o[i],       ref_rdata[i]);
    endtask

    task automatic cycle_begin();
        @(posedge clk);
        #1;
        cyc++;
        dmem_phase = phase_at(cyc);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            cycle_begin();
            for (int i = 0; i < NI; i++) begin
                mem_read_i[i]  = 1'b0;
                mem_write_i[i] = 1'b0;
            end
            @(negedge clk);
            for (int i = 0; i < NI; i++) check_inst(i, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One request; sync=1 issues it in a cycle with a phase rise,
    // rst_mid=1 pulses reset in the first WAIT_DATA cycle of a read.
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input bit sync, input bit rst_mid);
        int c0, c_rise, c_acc, c_rst, c_end;
        int c_done [NI];
        bit mis, wr_e, rd_e, act, e_en;
        mis  = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        mis  = (a[1:0] != 2'b00);
`endif
        wr_e = wr;
        rd_e = rd && !wr;

        cycle_begin();
        while (sync && !rise_at(cyc)) begin
            @(negedge clk);
            cycle_begin();
        end
        c0 = cyc;
        c_rise = c0 + 1;
        while (!rise_at(c_rise)) c_rise++;
        c_acc = c_rise + 1;
        for (int i = 0; i < NI; i++)
            c_done[i] = mis ? c0 + 1 : (wr_e ? c_acc + 1 : c_acc + lat_of(i) + 1);
        c_rst = c_acc + 1;
        c_end = rst_mid ? c_rst + 1 : ((c_done[0] > c_done[1]) ? c_done[0] : c_done[1]) + 1;

        for (int c = c0; c <= c_end; c++) begin
            if (c != c0) cycle_begin();
            reset = rst_mid && (cyc == c_rst);
            addr  = a;
            wdata = wd;
            for (int i = 0; i < NI; i++) begin
                act = rst_mid ? (cyc <= c_rst) : (cyc <= c_done[i]);
                mem_read_i[i]  = rd && act;
                mem_write_i[i] = wr && act;
                if (rst_mid && cyc == c_rst + 1) begin
                    ref_rdata[i]  = '0;
                    ref_maddr[i]  = '0;
                    ref_mwdata[i] = '0;
                end
                if (!mis && cyc == c_acc && !(rst_mid && cyc > c_rst)) begin
                    ref_maddr[i]  = a;
                    ref_mwdata[i] = wd;
                end
                if (!rst_mid && rd_e && !mis && cyc == c_done[i])
                    ref_rdata[i] = ref_mem[a[7:2]];
            end
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                e_en = !mis && (cyc == c_acc);
                check_inst(i,
                           rst_mid ? (cyc <= c_rst) : (cyc < c_done[i]),
                           !rst_mid && (cyc == c_done[i]),
                           e_en,
                           e_en && wr_e);
`ifdef DMEM_ALIGN_CHECK_EN
                chk("misalign", i, 32'(misalign_o[i]), 32'(mis && cyc == c_done[i]));
`endif
            end
        end
        reset = 1'b0;
        if (wr_e && !mis && !rst_mid) ref_mem[a[7:2]] = wd;
        $display("op rd=%0b wr=%0b addr=%h wdata=%h req_cyc=%0d access_cyc=%0d rst_mid=%0b",
                 rd, wr, a, wd, c0, mis ? -1 : c_acc, rst_mid);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int sel;
        logic [31:0] ra, rw;
        reset    = 1'b1;
        mem_init = 1'b1;
        addr     = '0;
        wdata    = '0;
        ph_off   = int'($urandom_range(0, 5));
        dmem_phase = phase_at(0);
        for (int i = 0; i < NI; i++) begin
            mem_read_i[i]  = 1'b0;
            mem_write_i[i] = 1'b0;
            ref_rdata[i]   = '0;
            ref_maddr[i]   = '0;
            ref_mwdata[i]  = '0;
        end
        for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);

        repeat (3) cycle_begin();
        cycle_begin();
        reset    = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_inst(i, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);

        // Store then load back.
        do_op(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 1'b0);
        idle_cycles(1);
        // Request lands in a phase-rise cycle: access waits a full period.
        do_op(1'b1, 1'b0, 32'h20, 32'h0,         1'b1, 1'b0);
        do_op(1'b0, 1'b1, 32'h44, 32'h5555_AAAA, 1'b1, 1'b0);
        // Read and write together: store wins, rdata untouched.
        do_op(1'b1, 1'b1, 32'h24, 32'h1234_5678, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 32'h24, 32'h0,         1'b0, 1'b0);
        // Reset inside WAIT_DATA, then a normal load.
        do_op(1'b1, 1'b0, 32'h30, 32'h0,         1'b0, 1'b1);
        idle_cycles(3);
        do_op(1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
        do_op(1'b1, 1'b0, 32'h13, 32'h0,         1'b0, 1'b0);
        do_op(1'b0, 1'b1, 32'h12, 32'hCAFE_F00D, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 1'b0);
`endif

        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            rw  = $urandom;
            idle_cycles(int'($urandom_range(0, 3)));
            do_op(sel != 1, sel == 1 || sel == 2, ra, rw,
                  $urandom_range(0, 1) == 1, 1'b0);
        end
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Data-memory access sequencer for the MIPS datapath.
- Sits between the MEM-stage load/store request and the synchronous data memory.
- Consumes the divided memory phase signal `dmem_phase`, produced by the dmem clock divider (1 cycle low, 5 cycles high).
- Launches each access on a rising edge of that phase, stalls the pipeline until the access completes, and returns read data.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- MEM_LAT, 1, cycles from `mem_en` to valid `mem_rdata`; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- dmem_phase  in  1  divided memory phase from the dmem clock divider; level signal, sampled on clk.
- mem_read  in  1  MEM-stage load request.
- mem_write  in  1  MEM-stage store request.
- addr  in  ADDR_W  byte address; held stable by the CPU while stall=1.
- wdata  in  DATA_W  store data; held stable by the CPU while stall=1.
- stall  out  1  freeze pipeline.
- done  out  1  one-cycle pulse when the access completes.
- rdata  out  DATA_W  load result.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Clocking and reset: one clock `clk`; reset is synchronous and active-high, port named `reset`.
- Reset values: state=IDLE, phase_q=0, lat_cnt=0, rdata=0, done=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, latched op/addr/data=0.
- Edge detect: phase_rise = dmem_phase & ~phase_q, where phase_q is dmem_phase registered on clk.
- FSM states: IDLE, WAIT_EDGE, ACCESS, WAIT_DATA, RESP.
- IDLE:
  - If mem_read|mem_write, latch op, addr and wdata, then go to WAIT_EDGE.
  - If both are asserted, the write wins and the read is ignored.
  - phase_rise is not examined in IDLE.
- WAIT_EDGE: stay until phase_rise=1, then go to ACCESS. With the default divider the worst-case wait is 6 cycles.
- ACCESS: exactly one cycle.
  - Outputs: mem_en=1, mem_we=op_write, mem_addr/mem_wdata = latched values.
  - Next state: RESP for a write; WAIT_DATA for a read, with lat_cnt loaded to MEM_LAT-1.
- WAIT_DATA:
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0, capture mem_rdata into rdata and go to RESP.
  - With MEM_LAT=1 this state lasts one cycle.
- RESP: done=1 and stall=0 for one cycle, then go to IDLE.
- Request timing: a new request is accepted only in IDLE. Back-to-back requests therefore see IDLE on the cycle after RESP.
- stall = (IDLE & (mem_read|mem_write)) | WAIT_EDGE | ACCESS | WAIT_DATA. It is combinational and low in RESP.
- Memory-side outputs are decoded only from the state register, with no dependence on CPU inputs, so they are glitch-free.
- Outside ACCESS: mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last values.
- rdata holds its value until the next read completes; stores do not change it.
- Reset mid-operation: the FSM returns to IDLE on the next edge. If reset arrives during ACCESS, that cycle's strobe has already been presented and the memory may commit it; no done is issued.
- Latency, read: 1 (IDLE) + wait to phase_rise + 1 (ACCESS) + MEM_LAT + 1 (RESP).
- Latency, write: 1 + wait + 1 + 1.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output `misalign` (1 bit).
  - In IDLE, a request with addr[1:0]!=0 skips the memory access: go directly to RESP with done=1 and misalign=1 for that cycle.
  - No mem_en is issued and rdata is unchanged.
- Undefined:
  - No misalign port.
  - addr[1:0] is passed to memory unchecked.

Decomposition:
- Package dmem_ctrl_pkg holds:
  - the state encoding (5 states, 3-bit),
  - default ADDR_W/DATA_W constants,
  - the MEM_LAT range limits.
- Sub-module phase_edge_det (phase_q register plus rising-edge pulse) is natural and reusable by other divided-clock consumers.
- The FSM stays in the top module.

Test Plan:
- Write: dmem_phase from a rise=5/fall=1 model; mem_write=1, addr=0x10, wdata=0xDEADBEEF. Required: stall high until RESP; exactly one ACCESS cycle with mem_en=1, mem_we=1, mem_addr=0x10; done pulse for 1 cycle.
- Read-back: mem_read, addr=0x10, memory model MEM_LAT=1. Required: rdata=0xDEADBEEF in the done cycle; mem_we=0 throughout.
- Simultaneous request and edge: request arrives in the same cycle as phase_rise while in IDLE. Required: access waits for the next rise, 6 cycles later; exactly one mem_en pulse.
- Read and write together: mem_read=1 and mem_write=1. Required: write performed; rdata unchanged.
- Reset mid-operation: reset asserted during WAIT_DATA with MEM_LAT=3. Required: next cycle all outputs at reset values, no done; a subsequent read completes normally.
- Alignment check (with DMEM_ALIGN_CHECK_EN): addr=0x13. Required: misalign=1 and done=1 within 2 cycles; mem_en never asserted.
